// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with 2-flop sync, mid-bit sampling and a one-entry valid/ready buffer.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_8n1 #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       UART_RXD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t        r_state;
   logic          r_sync1;
   logic          r_rxs;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_frame_err;
   logic          r_overrun;
   logic          r_parity_err;
   logic          w_par_ok;

`ifdef UART_RX_PARITY_EN
   logic r_par;
   assign w_par_ok = ~^{r_shift, r_par};
   always_ff @(posedge clk or posedge reset)
      if (reset)
         r_par <= 1'b0;
      else if (r_state == PARITY && r_cnt == LAST)
         r_par <= r_rxs;
`else
   assign w_par_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1      <= 1'b1;
         r_rxs        <= 1'b1;
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_shift      <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_sync1      <= UART_RXD;
         r_rxs        <= r_sync1;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_parity_err <= 1'b0;
         // a delivery later in this block overrides the clear on a same-edge accept
         if (r_valid && rx_ready)
            r_valid <= 1'b0;
         case (r_state)
            IDLE:
               if (!r_rxs) begin
                  r_state <= START;
                  r_cnt   <= '0;
               end
            START:
               if (r_cnt == MID) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= r_rxs ? IDLE : DATA;
               end else
                  r_cnt <= r_cnt + ONE;
            DATA:
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rxs, r_shift[7:1]};
                  r_idx   <= r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (r_idx == 3'd7) r_state <= PARITY;
`else
                  if (r_idx == 3'd7) r_state <= STOP;
`endif
               end else
                  r_cnt <= r_cnt + ONE;
            PARITY:
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_state <= STOP;
               end else
                  r_cnt <= r_cnt + ONE;
            STOP:
               if (r_cnt == LAST) begin
                  r_cnt <= '0;
                  if (!r_rxs) begin
                     r_frame_err <= 1'b1;
                     r_state     <= WAIT_HIGH;
                  end else begin
                     r_state <= IDLE;
                     if (!w_par_ok)
                        r_parity_err <= 1'b1;
                     else if (!r_valid || rx_ready) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else
                        r_overrun <= 1'b1;
                  end
               end else
                  r_cnt <= r_cnt + ONE;
            WAIT_HIGH:
               if (r_rxs) r_state <= IDLE;
            default:
               r_state <= IDLE;
         endcase
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign busy       = (r_state != IDLE);
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign parity_err = r_parity_err;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed plus randomized frames; expected bytes queued at send time, popped by a monitor on accept.
module tb_uart_rx_8n1;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       UART_RXD = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, busy, frame_err, overrun, parity_err;

   int n_vec = 0, n_err = 0;
   int n_fe = 0, n_ov = 0, n_pe = 0, n_vh = 0;
   int exp_fe = 0, exp_ov = 0, exp_pe = 0;
   bit rnd = 1'b0;
   logic [7:0] q[$];

   always #5 clk = ~clk;

   uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .UART_RXD(UART_RXD),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_err(input string tag);
      chk({"frame_err_", tag}, n_fe, exp_fe);
      chk({"overrun_", tag}, n_ov, exp_ov);
      chk({"parity_err_", tag}, n_pe, exp_pe);
   endtask

   always @(negedge clk)
      if (!reset) begin
         if (rx_valid) n_vh++;
         if (frame_err) n_fe++;
         if (overrun) n_ov++;
         if (parity_err) n_pe++;
         if (rx_valid && rx_ready) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: got %02h expected none", rx_data);
            end else
               chk("rx_data", rx_data, q.pop_front());
         end
      end

   task automatic drive_bit(input logic b);
      UART_RXD = b;
      repeat (CPB) begin
         @(posedge clk);
         #1;
         if (rnd) rx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop, input bit pbad, input bit push);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d ^ pbad);
`endif
      if (!stop) exp_fe++;
`ifdef UART_RX_PARITY_EN
      else if (pbad) exp_pe++;
`endif
      else if (push) q.push_back(d);
      drive_bit(stop);
   endtask

   initial begin
      int vh0;
      logic [7:0] d;
      bit st, pb;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_errs", {frame_err, overrun, parity_err}, 3'b000);
      reset = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;

      vh0 = n_vh;
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      chk("busy_after_55", busy, 1'b0);
      chk("valid_cycles_55", n_vh - vh0, 1);
      chk("q_empty_55", q.size(), 0);
      chk_err("55");

      vh0 = n_vh;
      UART_RXD = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      UART_RXD = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_after_glitch", busy, 1'b0);
      chk("valid_after_glitch", n_vh - vh0, 0);
      chk_err("glitch");

      send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      chk("busy_wait_high", busy, 1'b1);
      drive_bit(1'b1);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1);
      chk("q_empty_3c", q.size(), 0);
      chk_err("a3_3c");

      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 1'b1);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      exp_ov++;
      chk("ovr_rx_data", rx_data, 8'h11);
      chk("ovr_rx_valid", rx_valid, 1'b1);
      chk_err("overrun");
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_drop_after_accept", rx_valid, 1'b0);
      chk("q_empty_11", q.size(), 0);

      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      chk("held_valid_5a", rx_valid, 1'b1);
      for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b0 : 1'b0);
      UART_RXD = 1'b0;
      repeat (CPB / 2) @(posedge clk);
      chk("busy_before_reset", busy, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rx_data", rx_data, 8'h00);
      chk("async_rx_valid", rx_valid, 1'b0);
      chk("async_busy", busy, 1'b0);
      chk("async_errs", {frame_err, overrun, parity_err}, 3'b000);
      UART_RXD = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      rx_ready = 1'b1;
      drive_bit(1'b1);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1);
      chk("q_empty_7e", q.size(), 0);
      chk_err("reset");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      drive_bit(1'b1);
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1);
      chk("q_empty_par", q.size(), 0);
      chk_err("parity");
`endif

      rnd = 1'b1;
      for (int k = 0; k < 40; k++) begin
         d  = 8'($urandom);
         st = ($urandom_range(0, 7) != 0);
         pb = ($urandom_range(0, 7) == 0);
         send_frame(d, st, pb, 1'b1);
         if (!st) begin
            repeat ($urandom_range(0, 2)) drive_bit(1'b0);
            drive_bit(1'b1);
         end
         repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      end
      rnd = 1'b0;
      rx_ready = 1'b1;
      drive_bit(1'b1);
      drive_bit(1'b1);
      chk("q_empty_random", q.size(), 0);
      chk("busy_end", busy, 1'b0);
      chk_err("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
